arc4_prga: RTL and testbench

ARC4 pseudo-random generation (PRGA) stage: the reader/consumer of the S memory that the init and key-schedule stages write. It reads a length-prefixed ciphertext from CT memory and walks S (i/j update, swap). It XORs each keystream byte with the ciphertext and writes a length-prefixed plaintext to PT memory. It sits after KSA under the top-level ARC4 controller and uses the same en/rdy handshake as init/ksa.

---
 rtl/arc4_pkg.sv | 21 ++
 rtl/arc4_prga_if.sv | 47 ++++
 rtl/arc4_prga.sv | 152 +++++++++++++++
 tb/tb_arc4_prga.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants for the init, KSA and PRGA stages.
package arc4_pkg;

    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned PRGA_CYCLES_PER_BYTE = 6;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        START,
        LEN,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WR_PT
    } prga_state_t;

endpackage

// File: rtl/arc4_prga_if.sv
// en/rdy handshake plus the S, CT and PT memory ports of the PRGA stage.
interface arc4_prga_if;
    import arc4_pkg::*;

    logic  en;
    logic  rdy;
    byte_t s_addr;
    byte_t s_rddata;
    byte_t s_wrdata;
    logic  s_wren;
    byte_t ct_addr;
    byte_t ct_rddata;
    byte_t pt_addr;
    byte_t pt_wrdata;
    logic  pt_wren;

    // PRGA side: drives the memory buses and rdy.
    modport master (
        input  en,
        input  s_rddata,
        input  ct_rddata,
        output rdy,
        output s_addr,
        output s_wrdata,
        output s_wren,
        output ct_addr,
        output pt_addr,
        output pt_wrdata,
        output pt_wren
    );

    // Controller / memory side.
    modport slave (
        output en,
        output s_rddata,
        output ct_rddata,
        input  rdy,
        input  s_addr,
        input  s_wrdata,
        input  s_wren,
        input  ct_addr,
        input  pt_addr,
        input  pt_wrdata,
        input  pt_wren
    );

endinterface

// File: rtl/arc4_prga.sv
// ARC4 PRGA: walks S, XORs keystream with a length-prefixed ciphertext, writes plaintext.
module arc4_prga
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    arc4_prga_if.master bus
);

    prga_state_t state, state_nxt;
    byte_t       i, i_nxt;
    byte_t       j, j_nxt;
    byte_t       k, k_nxt;
    byte_t       len, len_nxt;
    byte_t       si, si_nxt;
    byte_t       sj, sj_nxt;

    byte_t       jn_c;
    logic        rdy_c;
    byte_t       s_addr_c;
    byte_t       s_wrdata_c;
    logic        s_wren_c;
    byte_t       ct_addr_c;
    byte_t       pt_addr_c;
    byte_t       pt_wrdata_c;
    logic        pt_wren_c;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            len   <= len_nxt;
            si    <= si_nxt;
            sj    <= sj_nxt;
        end
    end

    // Next state, datapath updates and memory strobes.
    always_comb begin
        state_nxt   = state;
        i_nxt       = i;
        j_nxt       = j;
        k_nxt       = k;
        len_nxt     = len;
        si_nxt      = si;
        sj_nxt      = sj;
        jn_c        = byte_t'(j + bus.s_rddata);
        rdy_c       = 1'b0;
        s_addr_c    = '0;
        s_wrdata_c  = '0;
        s_wren_c    = 1'b0;
        ct_addr_c   = '0;
        pt_addr_c   = '0;
        pt_wrdata_c = '0;
        pt_wren_c   = 1'b0;

        case (state)
            IDLE: begin
                rdy_c = 1'b1;
                if (bus.en) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = byte_t'(1);
                    state_nxt = START;
                end
            end
            START: begin
                ct_addr_c = '0;
                state_nxt = LEN;
            end
            LEN: begin
                len_nxt     = bus.ct_rddata;
                pt_addr_c   = '0;
                pt_wrdata_c = bus.ct_rddata;
                pt_wren_c   = 1'b1;
                i_nxt       = byte_t'(1);
                state_nxt   = (bus.ct_rddata == '0) ? IDLE : RD_SI;
            end
            RD_SI: begin
                s_addr_c  = i;
                ct_addr_c = k;
                state_nxt = RD_SJ;
            end
            RD_SJ: begin
                ct_addr_c = k;
                si_nxt    = bus.s_rddata;
                s_addr_c  = jn_c;
                j_nxt     = jn_c;
                state_nxt = WR_SI;
            end
            WR_SI: begin
                ct_addr_c  = k;
                sj_nxt     = bus.s_rddata;
                s_addr_c   = i;
                s_wrdata_c = bus.s_rddata;
                s_wren_c   = 1'b1;
                state_nxt  = WR_SJ;
            end
            WR_SJ: begin
                // With i == j this rewrites the value just stored, so the swap stays correct.
                ct_addr_c  = k;
                s_addr_c   = j;
                s_wrdata_c = si;
                s_wren_c   = 1'b1;
                state_nxt  = RD_PAD;
            end
            RD_PAD: begin
                ct_addr_c = k;
                s_addr_c  = byte_t'(si + sj);
                state_nxt = WR_PT;
            end
            WR_PT: begin
                ct_addr_c   = k;
                pt_addr_c   = k;
                pt_wrdata_c = bus.s_rddata ^ bus.ct_rddata;
                pt_wren_c   = 1'b1;
                if (k == len) begin
                    state_nxt = IDLE;
                end else begin
                    k_nxt     = byte_t'(k + 8'd1);
                    i_nxt     = byte_t'(i + 8'd1);
                    state_nxt = RD_SI;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are masked while rst is high so an interrupted byte leaves no partial write.
    assign bus.rdy       = rdy_c;
    assign bus.s_addr    = s_addr_c;
    assign bus.s_wrdata  = s_wrdata_c;
    assign bus.s_wren    = s_wren_c & ~rst;
    assign bus.ct_addr   = ct_addr_c;
    assign bus.pt_addr   = pt_addr_c;
    assign bus.pt_wrdata = pt_wrdata_c;
    assign bus.pt_wren   = pt_wren_c & ~rst;

endmodule

// File: tb/tb_arc4_prga.sv
// Scoreboard bench for arc4_prga with behavioural S/CT/PT RAMs and an ARC4 reference model.
module tb_arc4_prga;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } pt_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic load_s;

    always #5 clk = ~clk;

    arc4_prga_if bus ();

    arc4_prga dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] s_mem    [256];
    logic [7:0] ct_mem   [256];
    logic [7:0] pt_mem   [256];
    logic [7:0] load_img [256];
    logic [7:0] m_s      [256];

    pt_exp_t exp_q [$];
    pt_exp_t mon_e;
    int      n_tests  = 0;
    int      n_fail   = 0;
    int      s_wr_cnt = 0;

    // One-cycle-latency RAMs; S can be bulk-loaded while the DUT is idle.
    always @(posedge clk) begin
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.ct_rddata <= ct_mem[bus.ct_addr];
        if (load_s) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= load_img[a];
        end else if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wrdata;
        end
        if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: every PT write is popped from the expectation queue and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_wren) s_wr_cnt <= s_wr_cnt + 1;
            if (bus.s_wren || bus.pt_wren)
                check("strobes_exclusive", int'(bus.s_wren & bus.pt_wren), 0);
            if (bus.pt_wren) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pt_unexpected: actual write pt[%0d]=%0d required none",
                             bus.pt_addr, bus.pt_wrdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pt_addr", int'(bus.pt_addr), int'(mon_e.addr));
                    check("pt_data", int'(bus.pt_wrdata), int'(mon_e.data));
                end
            end
        end
    end

    // Reference ARC4 PRGA over the model's copy of S; only the first nswap bytes take effect.
    task automatic model_run(input int len, input int nswap);
        int      mi;
        int      mj;
        int      a;
        int      b;
        pt_exp_t e;
        mi = 0;
        mj = 0;
        e.addr = 8'd0;
        e.data = 8'(len);
        exp_q.push_back(e);
        for (int k = 1; k <= len && k <= nswap; k++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(m_s[mi])) % 256;
            a = int'(m_s[mi]);
            b = int'(m_s[mj]);
            m_s[mi] = 8'(b);
            m_s[mj] = 8'(a);
            e.addr = 8'(k);
            e.data = m_s[(a + b) % 256] ^ ct_mem[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic load_s_from_img();
        for (int a = 0; a < 256; a++) m_s[a] = load_img[a];
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    task automatic img_identity();
        for (int a = 0; a < 256; a++) load_img[a] = 8'(a);
    endtask

    task automatic img_ksa_key();
        logic [7:0] key [3];
        logic [7:0] t;
        int         kj;
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        img_identity();
        kj = 0;
        for (int a = 0; a < 256; a++) begin
            kj = (kj + int'(load_img[a]) + int'(key[a % 3])) % 256;
            t = load_img[a];
            load_img[a] = load_img[kj];
            load_img[kj] = t;
        end
    endtask

    task automatic img_random_perm();
        logic [7:0] t;
        int         r;
        img_identity();
        for (int a = 255; a > 0; a--) begin
            r = int'($urandom_range(a, 0));
            t = load_img[a];
            load_img[a] = load_img[r];
            load_img[r] = t;
        end
    endtask

    task automatic ct_random(input int len);
        ct_mem[0] = 8'(len);
        for (int a = 1; a < 256; a++) ct_mem[a] = 8'($urandom_range(255, 0));
    endtask

    // mode 0: en toggles randomly while busy; mode 1: en held high until rdy.
    // abort_byte > 0 asserts rst during WR_SI of that byte.
    task automatic run_msg(input int len, input int mode, input int abort_byte);
        int cnt;
        int s0;
        int nsw;
        int mism;
        nsw = (abort_byte > 0) ? abort_byte - 1 : len;
        model_run(len, nsw);
        s0 = s_wr_cnt;
        @(negedge clk);
        check("rdy_before_start", int'(bus.rdy), 1);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        cnt = 1;
        while (1) begin
            if (abort_byte > 0 && cnt == 6 * abort_byte - 1) begin
                bus.en = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("rdy_after_abort", int'(bus.rdy), 1);
                check("outputs_after_abort",
                      int'(|{bus.s_addr, bus.ct_addr, bus.pt_addr, bus.s_wrdata,
                             bus.pt_wrdata, bus.s_wren, bus.pt_wren}), 0);
                exp_q.delete();
                break;
            end
            if (bus.rdy) begin
                bus.en = 1'b0;
                break;
            end
            if (cnt >= 2000) begin
                bus.en = 1'b0;
                check("busy_timeout", cnt, 6 * len + 3);
                break;
            end
            bus.en = (mode != 0) ? 1'b1 : 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            cnt++;
        end
        if (abort_byte == 0) check("busy_cycles", cnt, 6 * len + 3);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("s_write_count", s_wr_cnt - s0, 2 * nsw);
        @(posedge clk);
        #1;
        check("no_restart", int'(bus.rdy), 1);
        mism = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) mism++;
        check("s_state", mism, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string ptxt;
        int    mism;
        int    rlen;
        ptxt   = "Plaintext";
        rst    = 1'b1;
        load_s = 1'b0;
        bus.en = 1'b0;
        for (int a = 0; a < 256; a++) begin
            ct_mem[a] = 8'd0;
            pt_mem[a] = 8'hEE;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rdy", int'(bus.rdy), 1);
        check("reset_strobes", int'({bus.s_wren, bus.pt_wren}), 0);
        check("reset_addrs", int'(|{bus.s_addr, bus.ct_addr, bus.pt_addr,
                                    bus.s_wrdata, bus.pt_wrdata}), 0);

        // Empty message.
        img_identity();
        load_s_from_img();
        ct_mem[0] = 8'd0;
        run_msg(0, 0, 0);
        check("len0_pt0", int'(pt_mem[0]), 0);

        // Identity S, single byte.
        img_identity();
        load_s_from_img();
        ct_mem[0] = 8'd1;
        ct_mem[1] = 8'h41;
        run_msg(1, 0, 0);
        check("id1_pt0", int'(pt_mem[0]), 1);
        check("id1_pt1", int'(pt_mem[1]), 8'h43);

        // Identity S, two zero bytes: keystream 02 05 and s[2]/s[3] swapped.
        img_identity();
        load_s_from_img();
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h00;
        ct_mem[2] = 8'h00;
        run_msg(2, 0, 0);
        check("id2_pt1", int'(pt_mem[1]), 8'h02);
        check("id2_pt2", int'(pt_mem[2]), 8'h05);
        check("id2_s2", int'(s_mem[2]), 3);
        check("id2_s3", int'(s_mem[3]), 2);

        // Key "Key" test vector.
        img_ksa_key();
        load_s_from_img();
        ct_mem[0] = 8'd9;
        ct_mem[1] = 8'hBB; ct_mem[2] = 8'hF3; ct_mem[3] = 8'h16;
        ct_mem[4] = 8'hE8; ct_mem[5] = 8'hD9; ct_mem[6] = 8'h40;
        ct_mem[7] = 8'hAF; ct_mem[8] = 8'h0A; ct_mem[9] = 8'hD3;
        run_msg(9, 0, 0);
        mism = 0;
        for (int a = 1; a <= 9; a++) if (pt_mem[a] !== ptxt[a-1]) mism++;
        check("key_plaintext", mism, 0);

        // Random permutations and messages; S carries over between runs.
        img_random_perm();
        load_s_from_img();
        for (int r = 0; r < 4; r++) begin
            rlen = int'($urandom_range(40, 1));
            ct_random(rlen);
            run_msg(rlen, 0, 0);
        end

        // Reset during WR_SI of byte 3, then a fresh message on the current S.
        ct_random(6);
        run_msg(6, 0, 3);
        ct_random(5);
        run_msg(5, 0, 0);

        // Maximum length with en held high throughout.
        ct_random(255);
        run_msg(255, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
